// File: rtl/dm_dma_ctrl.sv
// dm_dma_ctrl: single-channel DMA between an external stream and DM, using only DM cycles the core leaves idle.
module dm_dma_ctrl #(
  parameter int DMA_SIZE  = 16,
  parameter int DMD_SIZE  = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_start,
  input  logic                 cfg_dir,
  input  logic [DMA_SIZE-1:0]  cfg_base,
  input  logic [DMA_SIZE-1:0]  cfg_stride,
  input  logic [CNT_WIDTH-1:0] cfg_count,
  input  logic                 ps_dm_cslt,
  input  logic                 ps_dm_wrb,
  input  logic [DMA_SIZE-1:0]  dg_dm_add,
  input  logic [DMD_SIZE-1:0]  bc_dt,
  output logic                 dm_cslt,
  output logic                 dm_wrb,
  output logic [DMA_SIZE-1:0]  dm_add,
  output logic [DMD_SIZE-1:0]  dm_wdt,
  input  logic [DMD_SIZE-1:0]  dm_rdt,
  input  logic                 ext_wr_valid,
  input  logic [DMD_SIZE-1:0]  ext_wr_data,
  output logic                 ext_wr_ready,
  output logic                 ext_rd_valid,
  output logic [DMD_SIZE-1:0]  ext_rd_data,
  input  logic                 ext_rd_ready,
  output logic                 dma_busy,
  output logic                 dma_done,
  output logic [15:0]          dma_conflict_cnt
);
  typedef enum logic [2:0] {IDLE, WR_XFER, RD_ISSUE, RD_CAP, RD_HOLD, DONE} state_t;
  state_t state_q, state_d;
  logic [DMA_SIZE-1:0] addr_q, addr_d, stride_q, stride_d;
  logic [CNT_WIDTH-1:0] rem_q, rem_d;
  logic rd_valid_q, rd_valid_d;
  logic [DMD_SIZE-1:0] rd_data_q, rd_data_d;
  logic [15:0] conf_q, conf_d;
  logic wr_fire, rd_issue, want;
  assign wr_fire  = state_q == WR_XFER && ext_wr_valid && !ps_dm_cslt;
  assign rd_issue = state_q == RD_ISSUE && !ps_dm_cslt;
  assign want     = (state_q == WR_XFER && ext_wr_valid) || state_q == RD_ISSUE;
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    stride_d   = stride_q;
    rem_d      = rem_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    conf_d     = (ps_dm_cslt && want && conf_q != 16'hFFFF) ? conf_q + 16'd1 : conf_q;
    unique case (state_q)
      IDLE: if (cfg_start) begin
        addr_d   = cfg_base;
        stride_d = cfg_stride;
        rem_d    = cfg_count;
        conf_d   = '0;
        state_d  = (cfg_count == '0) ? DONE : cfg_dir ? RD_ISSUE : WR_XFER;
      end
      WR_XFER: if (wr_fire) begin
        addr_d  = addr_q + stride_q;
        rem_d   = rem_q - 1'b1;
        state_d = (rem_q == 1) ? DONE : WR_XFER;
      end
      RD_ISSUE: state_d = ps_dm_cslt ? RD_ISSUE : RD_CAP;
      // The read was issued last cycle, so dm_rdt belongs to the DMA even if the core selects now.
      RD_CAP: begin
        rd_data_d  = dm_rdt;
        rd_valid_d = 1'b1;
        state_d    = RD_HOLD;
      end
      RD_HOLD: if (rd_valid_q && ext_rd_ready) begin
        rd_valid_d = 1'b0;
        addr_d     = addr_q + stride_q;
        rem_d      = rem_q - 1'b1;
        state_d    = (rem_q == 1) ? DONE : RD_ISSUE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      stride_q   <= '0;
      rem_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      conf_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      stride_q   <= stride_d;
      rem_q      <= rem_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      conf_q     <= conf_d;
    end
  end
  // Core path is a pure mux so it sees no added latency.
  assign dm_cslt          = ps_dm_cslt | wr_fire | rd_issue;
  assign dm_wrb           = ps_dm_cslt ? ps_dm_wrb : wr_fire;
  assign dm_add           = ps_dm_cslt ? dg_dm_add : (wr_fire || rd_issue) ? addr_q : '0;
  assign dm_wdt           = ps_dm_cslt ? bc_dt : wr_fire ? ext_wr_data : '0;
  assign ext_wr_ready     = state_q == WR_XFER && !ps_dm_cslt;
  assign ext_rd_valid     = rd_valid_q;
  assign ext_rd_data      = rd_data_q;
  assign dma_busy         = state_q != IDLE;
  assign dma_done         = state_q == DONE;
  assign dma_conflict_cnt = conf_q;
endmodule

// File: tb/tb_dm_dma_ctrl.sv
// tb_dm_dma_ctrl: table vectors, directed corner sequences and randomized transfers against a transaction-level model.
module tb_dm_dma_ctrl;
  logic clk = 1'b0, reset = 1'b0;
  logic cfg_start = 0, cfg_dir = 0;
  logic [15:0] cfg_base = 0, cfg_stride = 0;
  logic [7:0] cfg_count = 0;
  logic ps_dm_cslt = 0, ps_dm_wrb = 0;
  logic [15:0] dg_dm_add = 0, bc_dt = 0;
  logic dm_cslt, dm_wrb;
  logic [15:0] dm_add, dm_wdt, dm_rdt;
  logic ext_wr_valid = 0, ext_wr_ready, ext_rd_valid, ext_rd_ready = 0;
  logic [15:0] ext_wr_data = 0, ext_rd_data;
  logic dma_busy, dma_done;
  logic [15:0] dma_conflict_cnt;
  logic pre_we = 0;
  logic [15:0] pre_addr = 0, pre_data = 0;
  logic [15:0] mem [0:65535];
  logic [15:0] ref_mem [0:65535];
  int total = 0, bad = 0;

  typedef struct {
    logic ps, wrb;
    logic [15:0] add, dt;
    logic e_cs, e_wrb;
    logic [15:0] e_add, e_dt;
  } vec_t;
  vec_t tbl [5];

  dm_dma_ctrl dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_dir(cfg_dir), .cfg_base(cfg_base),
    .cfg_stride(cfg_stride), .cfg_count(cfg_count), .ps_dm_cslt(ps_dm_cslt), .ps_dm_wrb(ps_dm_wrb),
    .dg_dm_add(dg_dm_add), .bc_dt(bc_dt), .dm_cslt(dm_cslt), .dm_wrb(dm_wrb), .dm_add(dm_add),
    .dm_wdt(dm_wdt), .dm_rdt(dm_rdt), .ext_wr_valid(ext_wr_valid), .ext_wr_data(ext_wr_data),
    .ext_wr_ready(ext_wr_ready), .ext_rd_valid(ext_rd_valid), .ext_rd_data(ext_rd_data),
    .ext_rd_ready(ext_rd_ready), .dma_busy(dma_busy), .dma_done(dma_done),
    .dma_conflict_cnt(dma_conflict_cnt)
  );

  always #5 clk = ~clk;

  // Data memory behind the arbiter: read data appears the cycle after a read select.
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (dm_cslt) begin
      if (dm_wrb) mem[dm_add] <= dm_wdt;
      else dm_rdt <= mem[dm_add];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_in();
    cfg_start = 0; ps_dm_cslt = 0; ps_dm_wrb = 0; dg_dm_add = 0; bc_dt = 0;
    ext_wr_valid = 0; ext_wr_data = 0; ext_rd_ready = 0; pre_we = 0;
  endtask

  task automatic pre(input logic [15:0] a, input logic [15:0] d);
    pre_we = 1; pre_addr = a; pre_data = d; ref_mem[a] = d;
    cyc();
    pre_we = 0;
  endtask

  task automatic start(input logic dir, input logic [15:0] base, input logic [15:0] stride, input logic [7:0] cnt);
    cfg_start = 1; cfg_dir = dir; cfg_base = base; cfg_stride = stride; cfg_count = cnt;
    cyc();
    cfg_start = 0;
  endtask

  task automatic rnd_xfer();
    logic dir, want, pend, fin, done_exp, nd;
    logic [15:0] base, stride, a, wd, exp_rd;
    int cnt, k, since, conf;
    dir = 1'($urandom_range(0, 1));
    base = 16'($urandom);
    stride = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(0, 4));
    cnt = $urandom_range(0, 6);
    if (dir) for (int i = 0; i < cnt; i++) pre(16'(base + i * stride), 16'($urandom));
    start(dir, base, stride, 8'(cnt));
    k = 0; want = dir && cnt != 0; pend = 0; since = 0; conf = 0; exp_rd = 0;
    done_exp = (cnt == 0); fin = 0; wd = 16'($urandom);
    for (int c = 0; c < 400 && !fin; c++) begin
      nd = 0;
      ps_dm_cslt = $urandom_range(0, 9) < 3;
      ps_dm_wrb = 1'($urandom); dg_dm_add = 16'($urandom); bc_dt = 16'($urandom);
      ext_wr_valid = $urandom_range(0, 9) < 7; ext_wr_data = wd;
      ext_rd_ready = $urandom_range(0, 9) < 6;
      #1;
      a = 16'(base + k * stride);
      if (ps_dm_cslt) begin
        chk("r_core", {dm_cslt, dm_wrb, dm_add, dm_wdt}, {1'b1, ps_dm_wrb, dg_dm_add, bc_dt});
      end
      chk("r_done", dma_done, done_exp);
      chk("r_busy", dma_busy, 1);
      if (done_exp) begin
        chk("r_conf", dma_conflict_cnt, 16'(conf));
        if (!ps_dm_cslt) chk("r_done_cs", dm_cslt, 0);
        fin = 1;
      end else if (!dir) begin
        chk("r_wrdy", ext_wr_ready, !ps_dm_cslt);
        if (ext_wr_valid && ps_dm_cslt) conf++;
        if (ext_wr_valid && !ps_dm_cslt) begin
          chk("r_wr", {dm_cslt, dm_wrb, dm_add, dm_wdt}, {1'b1, 1'b1, a, wd});
          ref_mem[a] = wd; k++; wd = 16'($urandom);
          if (k == cnt) nd = 1;
        end else if (!ps_dm_cslt) chk("r_wr_idle", dm_cslt, 0);
      end else begin
        chk("r_rval", ext_rd_valid, pend && since >= 2);
        if (want && ps_dm_cslt) conf++;
        if (!ps_dm_cslt) chk("r_rdacc", {dm_cslt, dm_wrb, dm_add}, want ? {1'b1, 1'b0, a} : 18'h0);
        if (want && !ps_dm_cslt) begin
          want = 0; pend = 1; since = 0; exp_rd = ref_mem[a];
        end else if (pend && since >= 2 && ext_rd_ready) begin
          chk("r_rdata", ext_rd_data, exp_rd);
          pend = 0; k++;
          if (k == cnt) nd = 1; else want = 1;
        end
        if (pend) since++;
      end
      if (ps_dm_cslt && ps_dm_wrb) ref_mem[dg_dm_add] = bc_dt;
      cyc();
      if (nd) done_exp = 1;
    end
    if (!fin) begin
      total++; bad++;
      $display("FAIL r_timeout: transfer did not complete dir=%0d cnt=%0d", dir, cnt);
    end
    idle_in();
    #1;
    chk("r_idle", dma_busy, 0);
    cyc();
  endtask

  initial begin
    logic [15:0] wa [3];
    int w;
    idle_in();
    reset = 0;
    repeat (2) cyc();
    #1;
    chk("rst_busy", dma_busy, 0);
    chk("rst_done", dma_done, 0);
    chk("rst_wrdy", ext_wr_ready, 0);
    chk("rst_rval", ext_rd_valid, 0);
    chk("rst_rdata", ext_rd_data, 0);
    chk("rst_conf", dma_conflict_cnt, 0);
    chk("rst_cs", dm_cslt, 0);
    reset = 1;
    cyc();

    tbl[0] = '{1'b1, 1'b1, 16'h1234, 16'hABCD, 1'b1, 1'b1, 16'h1234, 16'hABCD};
    tbl[1] = '{1'b1, 1'b0, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 16'h0001};
    tbl[2] = '{1'b0, 1'b1, 16'h1234, 16'hABCD, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tbl[3] = '{1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tbl[4] = '{1'b1, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0000};
    for (int i = 0; i < 5; i++) begin
      ps_dm_cslt = tbl[i].ps; ps_dm_wrb = tbl[i].wrb; dg_dm_add = tbl[i].add; bc_dt = tbl[i].dt;
      ext_wr_valid = 1;
      #1;
      chk("tbl_arb", {dm_cslt, dm_wrb, dm_add, dm_wdt}, {tbl[i].e_cs, tbl[i].e_wrb, tbl[i].e_add, tbl[i].e_dt});
      chk("tbl_wrdy", ext_wr_ready, 0);
      cyc();
    end
    idle_in();
    cyc();

    // Uncontended write burst
    start(0, 16'h0100, 16'd2, 8'd4);
    ext_wr_valid = 1;
    for (int i = 0; i < 4; i++) begin
      ext_wr_data = 16'(16'hA0 + i);
      #1;
      chk("wr_acc", {dm_cslt, dm_wrb, dm_add, dm_wdt}, {1'b1, 1'b1, 16'(16'h0100 + 2 * i), 16'(16'hA0 + i)});
      chk("wr_rdy", ext_wr_ready, 1);
      cyc();
    end
    ext_wr_valid = 0;
    #1;
    chk("wr_done", dma_done, 1);
    chk("wr_done_cs", dm_cslt, 0);
    chk("wr_conf", dma_conflict_cnt, 0);
    cyc();
    #1;
    chk("wr_after", {dma_done, dma_busy}, 2'b00);
    for (int i = 0; i < 4; i++) chk("wr_mem", mem[16'(16'h0100 + 2 * i)], 16'(16'hA0 + i));

    // Core preemption mid-burst
    start(0, 16'h0300, 16'd2, 8'd4);
    ext_wr_valid = 1; w = 0;
    for (int c = 0; c < 7; c++) begin
      ps_dm_cslt = (c >= 1 && c <= 3); ps_dm_wrb = 0; dg_dm_add = 16'h5555; bc_dt = 16'h1234;
      ext_wr_data = 16'(16'hA0 + w);
      #1;
      if (ps_dm_cslt) begin
        chk("pre_core", {dm_cslt, dm_wrb, dm_add, dm_wdt}, {1'b1, 1'b0, 16'h5555, 16'h1234});
        chk("pre_rdy", ext_wr_ready, 0);
      end else begin
        chk("pre_dma", {dm_cslt, dm_wrb, dm_add, dm_wdt}, {1'b1, 1'b1, 16'(16'h0300 + 2 * w), 16'(16'hA0 + w)});
        chk("pre_rdy1", ext_wr_ready, 1);
        w++;
      end
      cyc();
    end
    idle_in();
    #1;
    chk("pre_done", dma_done, 1);
    chk("pre_conf", dma_conflict_cnt, 3);
    cyc();
    for (int i = 0; i < 4; i++) chk("pre_mem", mem[16'(16'h0300 + 2 * i)], 16'(16'hA0 + i));

    // Read with backpressure
    pre(16'h0200, 16'h1111);
    pre(16'h0201, 16'h2222);
    start(1, 16'h0200, 16'd1, 8'd2);
    #1;
    chk("rd_iss0", {dm_cslt, dm_wrb, dm_add}, {1'b1, 1'b0, 16'h0200});
    cyc();
    #1;
    chk("rd_cap0", ext_rd_valid, 0);
    cyc();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("rd_hold", {ext_rd_valid, ext_rd_data, dma_done}, {1'b1, 16'h1111, 1'b0});
      cyc();
    end
    ext_rd_ready = 1;
    #1;
    chk("rd_acc0", {ext_rd_valid, ext_rd_data}, {1'b1, 16'h1111});
    cyc();
    ext_rd_ready = 0;
    #1;
    chk("rd_iss1", {ext_rd_valid, dm_cslt, dm_wrb, dm_add}, {1'b0, 1'b1, 1'b0, 16'h0201});
    cyc();
    cyc();
    ext_rd_ready = 1;
    #1;
    chk("rd_acc1", {ext_rd_valid, ext_rd_data}, {1'b1, 16'h2222});
    cyc();
    ext_rd_ready = 0;
    #1;
    chk("rd_done", {dma_done, ext_rd_valid}, 2'b10);
    cyc();
    #1;
    chk("rd_after", {dma_done, dma_busy}, 2'b00);

    // Zero-length transfer
    start(0, 16'h0AAA, 16'd1, 8'd0);
    #1;
    chk("z_done", {dma_done, dm_cslt}, 2'b10);
    cyc();
    #1;
    chk("z_after", {dma_done, dma_busy, dm_cslt}, 3'b000);

    // Address wrap, with a start request ignored while busy
    wa[0] = 16'h0001; wa[1] = 16'h0000; wa[2] = 16'hFFFF;
    start(0, 16'h0001, 16'hFFFF, 8'd3);
    ext_wr_valid = 1;
    for (int i = 0; i < 3; i++) begin
      ext_wr_data = 16'(16'hB0 + i);
      if (i == 0) begin
        cfg_start = 1; cfg_dir = 1; cfg_base = 16'h4000; cfg_stride = 16'd5; cfg_count = 8'd9;
      end
      #1;
      chk("wrap_acc", {dm_cslt, dm_wrb, dm_add, dm_wdt}, {1'b1, 1'b1, wa[i], 16'(16'hB0 + i)});
      cyc();
      cfg_start = 0;
    end
    ext_wr_valid = 0;
    #1;
    chk("wrap_done", dma_done, 1);
    cyc();
    #1;
    chk("wrap_after", dma_busy, 0);

    // Read conflicts, capture under core select, then reset while holding
    pre(16'h0210, 16'h3333);
    pre(16'h0211, 16'h4444);
    start(1, 16'h0210, 16'd1, 8'd2);
    ps_dm_cslt = 1; ps_dm_wrb = 0; dg_dm_add = 16'h0020;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("rc_core", {dm_cslt, dm_wrb, dm_add}, {1'b1, 1'b0, 16'h0020});
      cyc();
    end
    ps_dm_cslt = 0;
    #1;
    chk("rc_iss", {dm_cslt, dm_wrb, dm_add}, {1'b1, 1'b0, 16'h0210});
    cyc();
    ps_dm_cslt = 1; dg_dm_add = 16'h0211;
    cyc();
    ps_dm_cslt = 0;
    #1;
    chk("rc_hold", {ext_rd_valid, ext_rd_data}, {1'b1, 16'h3333});
    chk("rc_conf", dma_conflict_cnt, 2);
    reset = 0;
    cyc();
    #1;
    chk("rr_state", {ext_rd_valid, dma_busy, dma_done}, 3'b000);
    chk("rr_conf", dma_conflict_cnt, 0);
    reset = 1;
    cyc();
    #1;
    chk("rr_nodone", {dma_done, dma_busy}, 2'b00);
    start(0, 16'h0500, 16'd1, 8'd1);
    ext_wr_valid = 1; ext_wr_data = 16'h00C0;
    #1;
    chk("rr_wr", {dm_cslt, dm_wrb, dm_add, dm_wdt}, {1'b1, 1'b1, 16'h0500, 16'h00C0});
    cyc();
    ext_wr_valid = 0;
    #1;
    chk("rr_done", dma_done, 1);
    cyc();

    for (int t = 0; t < 40; t++) rnd_xfer();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
